// File: rtl/alu_ctrl.sv
// alu_ctrl: accumulator-machine controller that sequences one instruction at a
// time through an external registered ALU.
// Each instruction goes IDLE -> ISSUE -> WAIT, with write-back at the end of WAIT.
// SKZ can skip the next instruction; HLT parks the controller until resume.
// Optional build macro: ALU_CTRL_CHECK_EN adds a reference model that compares
// against alu_out and drives a sticky chk_err flag.

package alu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

endpackage

module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_opcode,
    input  logic [WIDTH-1:0] instr_data,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_data,
    output logic [WIDTH-1:0] alu_accum,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             st_valid,
    output logic [WIDTH-1:0] st_data,
    output logic             halted,
    input  logic             resume,
    output logic             chk_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t           state_q;
    opcode_t          op_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] accum_q;
    logic [WIDTH-1:0] accum_d;
    logic             skip_q;
    logic             ready_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             st_valid_q;
    logic [WIDTH-1:0] st_data_q;
    logic             halted_q;
    logic             hs_c;

    assign hs_c = instr_valid & ready_q;

    // Accumulator write-back value: only data-producing opcodes take the ALU result
    always_comb begin
        accum_d = accum_q;
        case (op_q)
            OP_ADD, OP_AND, OP_XOR, OP_LDA: accum_d = alu_out;
            default:                        accum_d = accum_q;
        endcase
    end

    // Controller FSM with registered outputs; the captured op/data double as the ALU drive
    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q     <= S_IDLE;
            op_q        <= OP_HLT;
            data_q      <= '0;
            accum_q     <= '0;
            skip_q      <= 1'b0;
            ready_q     <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            st_valid_q  <= 1'b0;
            st_data_q   <= '0;
            halted_q    <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            st_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hs_c) begin
                        if (skip_q) begin
                            // Skipped instruction is swallowed without touching the ALU
                            skip_q <= 1'b0;
                        end else begin
                            op_q    <= opcode_t'(instr_opcode);
                            data_q  <= instr_data;
                            ready_q <= 1'b0;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    accum_q     <= accum_d;
                    res_valid_q <= 1'b1;
                    res_data_q  <= accum_d;
                    op_q        <= OP_HLT;
                    data_q      <= '0;
                    if (op_q == OP_SKZ) begin
                        skip_q <= alu_zero;
                    end
                    if (op_q == OP_STO) begin
                        st_valid_q <= 1'b1;
                        st_data_q  <= accum_q;
                    end
                    if (op_q == OP_HLT) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        state_q  <= S_IDLE;
                        halted_q <= 1'b0;
                        ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = ready_q;
    assign alu_opcode  = op_q;
    assign alu_data    = data_q;
    assign alu_accum   = accum_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign st_valid    = st_valid_q;
    assign st_data     = st_data_q;
    assign halted      = halted_q;

`ifdef ALU_CTRL_CHECK_EN
    logic [WIDTH-1:0] exp_c;
    logic             chk_en_c;
    logic             chk_err_q;

    // Reference result for the data-producing opcodes
    always_comb begin
        exp_c    = accum_q;
        chk_en_c = 1'b1;
        case (op_q)
            OP_ADD:  exp_c = accum_q + data_q;
            OP_AND:  exp_c = accum_q & data_q;
            OP_XOR:  exp_c = accum_q ^ data_q;
            OP_LDA:  exp_c = data_q;
            default: chk_en_c = 1'b0;
        endcase
    end

    // Sticky mismatch flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_) begin
            chk_err_q <= 1'b0;
        end else if ((state_q == S_WAIT) && chk_en_c && (alu_out != exp_c)) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: table of directed instructions plus
// hand-written sequences for HALT, reset-in-WAIT and the result checker.
`timescale 1ns/1ps

module tb_alu_ctrl;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

`ifdef ALU_CTRL_CHECK_EN
    localparam logic CHK_EXP = 1'b1;
`else
    localparam logic CHK_EXP = 1'b0;
`endif

    logic       clk;
    logic       rst_;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] instr_opcode;
    logic [7:0] instr_data;
    logic [2:0] alu_opcode;
    logic [7:0] alu_data;
    logic [7:0] alu_accum;
    logic [7:0] alu_out;
    logic       alu_zero;
    logic       res_valid;
    logic [7:0] res_data;
    logic       st_valid;
    logic [7:0] st_data;
    logic       halted;
    logic       resume;
    logic       chk_err;

    logic       force_zero;
    logic [7:0] alu_res_c;

    int checks;
    int failures;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        int         exp_res;
        int         exp_st;
        logic [7:0] exp_acc;
        logic       exp_zero;
    } vec_t;

    vec_t vq[$];

    alu_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_data   (instr_data),
        .alu_opcode   (alu_opcode),
        .alu_data     (alu_data),
        .alu_accum    (alu_accum),
        .alu_out      (alu_out),
        .alu_zero     (alu_zero),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .st_valid     (st_valid),
        .st_data      (st_data),
        .halted       (halted),
        .resume       (resume),
        .chk_err      (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External registered ALU
    always_comb begin
        alu_res_c = alu_accum;
        case (alu_opcode)
            OP_ADD:  alu_res_c = alu_accum + alu_data;
            OP_AND:  alu_res_c = alu_accum & alu_data;
            OP_XOR:  alu_res_c = alu_accum ^ alu_data;
            OP_LDA:  alu_res_c = alu_data;
            default: alu_res_c = alu_accum;
        endcase
    end

    always @(posedge clk) begin
        alu_out  <= force_zero ? 8'h00 : alu_res_c;
        alu_zero <= (alu_accum == 8'h00);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [2:0] op, input logic [7:0] d, input int res,
                           input int st, input logic [7:0] acc, input logic zero);
        vec_t v;
        v.op = op; v.data = d; v.exp_res = res; v.exp_st = st; v.exp_acc = acc; v.exp_zero = zero;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        rst_        = 1'b0;
        instr_valid = 1'b0;
        resume      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_ = 1'b1;
    endtask

    // Offer one instruction and observe the following four cycles
    task automatic run_instr(input logic [2:0] op, input logic [7:0] d,
                             output int res_cnt, output int res_lat, output logic [7:0] rdata,
                             output int st_cnt, output logic [7:0] sdata, output logic zero_w);
        int n;
        res_cnt = 0; res_lat = 0; rdata = 8'h00; st_cnt = 0; sdata = 8'h00; zero_w = 1'b0;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_before_offer", 32'(instr_ready), 32'd1);
        instr_valid  = 1'b1;
        instr_opcode = op;
        instr_data   = d;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            if (k == 1) zero_w = alu_zero;
            if (res_valid) begin
                if (res_cnt == 0) begin
                    res_lat = k + 1;
                    rdata   = res_data;
                end
                res_cnt++;
            end
            if (st_valid) begin
                st_cnt++;
                sdata = st_data;
            end
        end
    endtask

    initial begin
        int         rc, rl, sc;
        logic [7:0] rd, sd;
        logic       zw;
        int         halt_cnt;

        checks = 0; failures = 0;
        force_zero = 1'b0; instr_opcode = 3'd0; instr_data = 8'h00;
        do_reset();

        // Reset state
        check("rst_ready",     32'(instr_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid),   32'd0);
        check("rst_st_valid",  32'(st_valid),    32'd0);
        check("rst_halted",    32'(halted),      32'd0);
        check("rst_alu_op",    32'(alu_opcode),  32'(OP_HLT));
        check("rst_alu_data",  32'(alu_data),    32'h00);
        check("rst_alu_accum", 32'(alu_accum),   32'h00);
        check("rst_res_data",  32'(res_data),    32'h00);
        check("rst_st_data",   32'(st_data),     32'h00);
        check("rst_chk_err",   32'(chk_err),     32'd0);

        //       op      data   res st acc    zero-during-WAIT
        add_vec(OP_LDA, 8'h37, 1, 0, 8'h37, 1'b1);
        add_vec(OP_LDA, 8'h12, 1, 0, 8'h12, 1'b0);
        add_vec(OP_ADD, 8'h07, 1, 0, 8'h19, 1'b0);
        add_vec(OP_LDA, 8'h35, 1, 0, 8'h35, 1'b0);
        add_vec(OP_AND, 8'h1F, 1, 0, 8'h15, 1'b0);
        add_vec(OP_LDA, 8'h1D, 1, 0, 8'h1D, 1'b0);
        add_vec(OP_XOR, 8'h1E, 1, 0, 8'h03, 1'b0);
        add_vec(OP_LDA, 8'h02, 1, 0, 8'h02, 1'b0);
        add_vec(OP_ADD, 8'hFF, 1, 0, 8'h01, 1'b0);
        add_vec(OP_JMP, 8'h44, 1, 0, 8'h01, 1'b0);
        add_vec(OP_LDA, 8'h00, 1, 0, 8'h00, 1'b0);
        add_vec(OP_SKZ, 8'h00, 1, 0, 8'h00, 1'b1);
        add_vec(OP_ADD, 8'h05, 0, 0, 8'h00, 1'b1);
        add_vec(OP_LDA, 8'h72, 1, 0, 8'h72, 1'b1);
        add_vec(OP_LDA, 8'h10, 1, 0, 8'h10, 1'b0);
        add_vec(OP_SKZ, 8'h00, 1, 0, 8'h10, 1'b0);
        add_vec(OP_ADD, 8'h05, 1, 0, 8'h15, 1'b0);
        add_vec(OP_LDA, 8'h72, 1, 0, 8'h72, 1'b0);
        add_vec(OP_LDA, 8'h00, 1, 0, 8'h00, 1'b0);
        add_vec(OP_SKZ, 8'h00, 1, 0, 8'h00, 1'b1);
        add_vec(OP_SKZ, 8'h00, 0, 0, 8'h00, 1'b1);
        add_vec(OP_ADD, 8'h05, 1, 0, 8'h05, 1'b1);
        add_vec(OP_LDA, 8'hDA, 1, 0, 8'hDA, 1'b0);
        add_vec(OP_STO, 8'h00, 1, 1, 8'hDA, 1'b0);
        add_vec(OP_AND, 8'h00, 1, 0, 8'h00, 1'b0);

        foreach (vq[i]) begin
            run_instr(vq[i].op, vq[i].data, rc, rl, rd, sc, sd, zw);
            check($sformatf("v%0d_res_cnt", i), 32'(rc), 32'(vq[i].exp_res));
            if (vq[i].exp_res != 0) begin
                check($sformatf("v%0d_latency", i),  32'(rl), 32'd3);
                check($sformatf("v%0d_res_data", i), 32'(rd), 32'(vq[i].exp_acc));
            end
            check($sformatf("v%0d_accum", i),    32'(alu_accum), 32'(vq[i].exp_acc));
            check($sformatf("v%0d_st_cnt", i),   32'(sc),        32'(vq[i].exp_st));
            if (vq[i].exp_st != 0) begin
                check($sformatf("v%0d_st_data", i), 32'(sd), 32'(vq[i].exp_acc));
            end
            check($sformatf("v%0d_alu_zero", i), 32'(zw), 32'(vq[i].exp_zero));
        end
        check("chk_err_clean_run", 32'(chk_err), 32'd0);

        // HLT: completes, then holds off instructions until resume
        run_instr(OP_HLT, 8'h00, rc, rl, rd, sc, sd, zw);
        check("hlt_res_cnt", 32'(rc), 32'd1);
        check("hlt_latency", 32'(rl), 32'd3);
        check("hlt_st_cnt",  32'(sc), 32'd0);
        check("hlt_halted",  32'(halted), 32'd1);
        instr_valid  = 1'b1;
        instr_opcode = OP_LDA;
        instr_data   = 8'hEE;
        halt_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (halted && !instr_ready) halt_cnt++;
        end
        check("hlt_hold_cycles", 32'(halt_cnt), 32'd10);
        check("hlt_alu_op_idle", 32'(alu_opcode), 32'(OP_HLT));
        instr_valid = 1'b0;
        resume      = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        check("resume_halted", 32'(halted),      32'd0);
        check("resume_ready",  32'(instr_ready), 32'd1);
        check("resume_accum",  32'(alu_accum),   32'h00);
        resume = 1'b1;
        @(posedge clk); #1;
        resume = 1'b0;
        check("resume_idle_ignored", 32'(halted), 32'd0);

        // Reset asserted in WAIT of an ADD aborts it
        run_instr(OP_LDA, 8'h20, rc, rl, rd, sc, sd, zw);
        check("pre_abort_accum", 32'(alu_accum), 32'h20);
        instr_valid  = 1'b1;
        instr_opcode = OP_ADD;
        instr_data   = 8'h07;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("wait_alu_op",   32'(alu_opcode), 32'(OP_ADD));
        check("wait_alu_data", 32'(alu_data),   32'h07);
        rst_ = 1'b0;
        @(posedge clk); #1;
        rst_ = 1'b1;
        rc = 0;
        if (res_valid) rc++;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (res_valid) rc++;
        end
        check("abort_res_cnt",  32'(rc),          32'd0);
        check("abort_accum",    32'(alu_accum),   32'h00);
        check("abort_ready",    32'(instr_ready), 32'd1);
        check("abort_alu_op",   32'(alu_opcode),  32'(OP_HLT));
        check("abort_res_data", 32'(res_data),    32'h00);

        // Result checker: ALU returns 0 for ADD 0x07 with accum 0x12
        run_instr(OP_LDA, 8'h12, rc, rl, rd, sc, sd, zw);
        force_zero = 1'b1;
        run_instr(OP_ADD, 8'h07, rc, rl, rd, sc, sd, zw);
        force_zero = 1'b0;
        check("bad_alu_res_data", 32'(rd),      32'h00);
        check("chk_err_set",      32'(chk_err), 32'(CHK_EXP));
        run_instr(OP_LDA, 8'h33, rc, rl, rd, sc, sd, zw);
        check("chk_err_sticky",   32'(chk_err), 32'(CHK_EXP));
        check("after_chk_res",    32'(rd),      32'h33);
        do_reset();
        check("chk_err_reset",    32'(chk_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, data/accumulator width in bits; only 8 is supported.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  controller accepts instruction this cycle.
REQ-006 instr_opcode  input  3  opcode_t from typedefs (HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7).
REQ-007 instr_data  input  WIDTH  instruction operand.
REQ-008 alu_opcode  output  3  opcode driven to ALU.
REQ-009 alu_data  output  WIDTH  operand driven to ALU.
REQ-010 alu_accum  output  WIDTH  accumulator register driven to ALU.
REQ-011 alu_out  input  WIDTH  registered ALU result.
REQ-012 alu_zero  input  1  ALU zero flag (accum == 0).
REQ-013 res_valid  output  1  one-cycle pulse: instruction completed.
REQ-014 res_data  output  WIDTH  accumulator value after completion.
REQ-015 st_valid / st_data  output  1 / WIDTH  one-cycle store strobe and stored value (STO).
REQ-016 halted  output  1  controller in HALT.
REQ-017 resume  input  1  leave HALT.
REQ-018 chk_err  output  1  sticky result-mismatch flag (see Configuration).

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, HALT; IDLE after reset.
REQ-020 instr_ready = 1 only in IDLE; handshake = instr_valid & instr_ready; opcode/data captured into internal regs, IDLE->ISSUE.
REQ-021 ISSUE: alu_opcode/alu_data = captured regs, alu_accum = accum; ISSUE->WAIT unconditionally.
REQ-022 alu_* outputs hold values from ISSUE through WAIT; in IDLE/HALT alu_opcode = HLT, alu_data = 0.
REQ-023 WAIT: alu_out and alu_zero sampled at end of cycle; WAIT->IDLE (HLT: WAIT->HALT).
REQ-024 Write-back at end of WAIT: ADD, AND, XOR, LDA load accum <= alu_out; HLT, SKZ, STO, JMP leave accum unchanged.
REQ-025 ADD wraps modulo 2^WIDTH; no carry output.
REQ-026 res_valid pulses the cycle after WAIT, res_data = updated accum; handshake-to-res_valid latency 3 cycles; max throughput one instruction per 3 cycles.
REQ-027 STO: st_valid pulses with res_valid, st_data = accum.
REQ-028 SKZ: if alu_zero = 1 in WAIT, skip flag set; next accepted instruction is consumed without ISSUE/WAIT, no ALU activity, no res_valid, no st_valid, accum unchanged; flag cleared; controller stays IDLE.
REQ-029 SKZ with alu_zero = 0: no skip; res_valid still pulses.
REQ-030 Consecutive SKZ: a skipped SKZ does not evaluate zero.
REQ-031 JMP: treated as no-op with res_valid pulse.
REQ-032 HLT: res_valid pulses; halted = 1 in HALT; instr_ready = 0; resume = 1 -> IDLE next cycle; resume ignored outside HALT.
REQ-033 Skip flag persists across HALT.

Reset
REQ-034 rst_ = 0 at a rising edge: state IDLE, accum 0, captured regs 0, skip flag 0, chk_err 0.
REQ-035 Outputs during/after reset: res_valid 0, st_valid 0, halted 0, alu_opcode HLT, alu_data 0, alu_accum 0, res_data 0, st_data 0, instr_ready 1 after reset releases.
REQ-036 Reset in ISSUE/WAIT aborts instruction: no write-back, no res_valid.

Configuration
REQ-037 Macro ALU_CTRL_CHECK_EN defined: internal reference model computes expected result from captured opcode/data/accum; mismatch with alu_out in WAIT sets chk_err (sticky until reset).
REQ-038 Macro undefined: no model logic; chk_err tied to 0.

Verification
REQ-039 Reset, LDA 0x37 -> res_valid 3 cycles after handshake, res_data 0x37, alu_zero 1 during that instruction.
REQ-040 accum 0x12, ADD 0x07 -> 0x19; then AND 0x1F with accum 0x35 -> 0x15; XOR 0x1E with accum 0x1D -> 0x03; ADD 0xFF with accum 0x02 -> 0x01 (wrap).
REQ-041 accum 0x00, SKZ then ADD 0x05 then LDA 0x72 -> ADD discarded, one res_valid for SKZ, accum 0x72 at end; repeat with accum 0x10 -> ADD executes, accum 0x15 before LDA.
REQ-042 accum 0xDA, STO -> st_valid one cycle, st_data 0xDA; HLT -> halted 1, instr_ready 0 for 10 cycles, resume -> IDLE next cycle.
REQ-043 Assert rst_ = 0 during WAIT of ADD -> no res_valid, accum 0, state IDLE.
REQ-044 ALU_CTRL_CHECK_EN defined, ALU model forced to return 0x00 for ADD 0x07 with accum 0x12 -> chk_err 1 and stays 1 until reset; macro undefined -> chk_err 0.
